// File: rtl/tt_sweep.sv
// tt_sweep: clocked truth-table sweep engine for a small combinational function.
// Walks x_out through every input vector in ascending order. Each vector is held
// for SETTLE+1 cycles, and the function output s_in is captured into table_out.
// Optional build macro TT_SWEEP_COMPARE_EN adds a compare against a golden table
// through the expected, mismatch and first_err ports.
module tt_sweep #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        x_out,
  input  logic                   s_in,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out
`ifdef TT_SWEEP_COMPARE_EN
  ,
  input  logic [(2**N_IN)-1:0]   expected,
  output logic                   mismatch,
  output logic [N_IN-1:0]        first_err
`endif
);

  localparam int unsigned NumVec = 2 ** N_IN;
  // The index carries one spare bit so the last-vector compare never wraps.
  localparam logic [N_IN:0] LastIdx  = (N_IN + 1)'(NumVec - 1);
  localparam logic [3:0]    SettleLd = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_IN:0]       idx_q, idx_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [N_IN-1:0]     x_q, x_d;
  logic [NumVec-1:0]   table_q, table_d;

  // Next-state, vector index, settle counter and capture logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    table_d = table_q;
    unique case (state_q)
      StIdle: begin
        x_d = '0;
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          cnt_d   = SettleLd;
          table_d = '0;
        end
      end
      StRun: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          table_d[idx_q[N_IN-1:0]] = s_in;
          if (idx_q == LastIdx) begin
            state_d = StDone;
            x_d     = '0;
          end else begin
            idx_d = idx_q + (N_IN + 1)'(1);
            cnt_d = SettleLd;
            // x_out is registered, so it follows the new index at this same edge.
            x_d   = idx_d[N_IN-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        x_d     = '0;
      end
      default: begin
        state_d = StIdle;
        x_d     = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      table_q <= table_d;
    end
  end

  // Outputs are decoded straight from registers, so there is no path from start.
  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    x_out     = x_q;
    table_out = table_q;
  end

`ifdef TT_SWEEP_COMPARE_EN
  logic [NumVec-1:0] diff;
  logic [N_IN-1:0]   ferr_calc;
  logic              mismatch_q, mismatch_d;
  logic [N_IN-1:0]   first_err_q, first_err_d;

  // Golden compare on the final table; results are captured on the edge into DONE.
  always_comb begin
    diff      = table_d ^ expected;
    ferr_calc = '0;
    // Scan downward so the lowest differing index wins.
    for (int i = int'(NumVec) - 1; i >= 0; i--) begin
      if (diff[i]) begin
        ferr_calc = N_IN'(i);
      end
    end
    mismatch_d  = mismatch_q;
    first_err_d = first_err_q;
    if ((state_q == StIdle) && start) begin
      mismatch_d  = 1'b0;
      first_err_d = '0;
    end else if ((state_q == StRun) && (state_d == StDone)) begin
      mismatch_d  = |diff;
      first_err_d = ferr_calc;
    end
  end

  // Compare result registers; held until the next start or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q  <= 1'b0;
      first_err_q <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      first_err_q <= first_err_d;
    end
  end

  // Compare outputs.
  always_comb begin
    mismatch  = mismatch_q;
    first_err = first_err_q;
  end
`endif

endmodule

// File: tb/tb_tt_sweep.sv
// Testbench for tt_sweep: three instances (N_IN/SETTLE = 2/1, 2/0, 3/2) drive
// function tables held in the bench. Results are checked against a timing/value
// model computed from the sweep rules.
module tb_tt_sweep;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [1:0] x_a, x_b;
  logic [2:0] x_c;
  logic s_a, s_b, s_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [3:0] tbl_a, tbl_b;
  logic [7:0] tbl_c;
  logic [3:0] func_a = '0, func_b = '0;
  logic [7:0] func_c = '0;
`ifdef TT_SWEEP_COMPARE_EN
  logic [3:0] gold_a = '0, gold_b = '0;
  logic [7:0] gold_c = '0;
  logic mm_a, mm_b, mm_c;
  logic [1:0] fe_a, fe_b;
  logic [2:0] fe_c;
`endif

  int checks = 0;
  int failures = 0;

  // Function under sweep: a lookup table indexed by the applied vector.
  assign s_a = func_a[x_a];
  assign s_b = func_b[x_b];
  assign s_c = func_c[x_c];

  always #5 clk = ~clk;

  tt_sweep #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .x_out(x_a), .s_in(s_a),
    .busy(busy_a), .done(done_a), .table_out(tbl_a)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(gold_a), .mismatch(mm_a), .first_err(fe_a)
`endif
  );

  tt_sweep #(.N_IN(2), .SETTLE(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .x_out(x_b), .s_in(s_b),
    .busy(busy_b), .done(done_b), .table_out(tbl_b)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(gold_b), .mismatch(mm_b), .first_err(fe_b)
`endif
  );

  tt_sweep #(.N_IN(3), .SETTLE(2)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .x_out(x_c), .s_in(s_c),
    .busy(busy_c), .done(done_c), .table_out(tbl_c)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(gold_c), .mismatch(mm_c), .first_err(fe_c)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic sample(input int inst, output logic [2:0] x, output logic b, output logic d,
                        output logic [7:0] t);
    case (inst)
      0: begin x = {1'b0, x_a}; b = busy_a; d = done_a; t = {4'b0, tbl_a}; end
      1: begin x = {1'b0, x_b}; b = busy_b; d = done_b; t = {4'b0, tbl_b}; end
      default: begin x = x_c; b = busy_c; d = done_c; t = tbl_c; end
    endcase
  endtask

`ifdef TT_SWEEP_COMPARE_EN
  task automatic sample_cmp(input int inst, output logic m, output logic [2:0] fe);
    case (inst)
      0: begin m = mm_a; fe = {1'b0, fe_a}; end
      1: begin m = mm_b; fe = {1'b0, fe_b}; end
      default: begin m = mm_c; fe = fe_c; end
    endcase
  endtask
`endif

  // Full sweep on one instance; optional second start pulse during cycle restart_at.
  task automatic sweep(input int inst, input logic [7:0] f, input logic [7:0] golden,
                       input int restart_at, input string tag);
    int settle, nvec, total, vec;
    logic [7:0] exp_tbl, part;
    logic [2:0] x;
    logic b, d;
    logic [7:0] t;
`ifdef TT_SWEEP_COMPARE_EN
    logic exp_mm, m;
    logic [2:0] exp_fe, fe;
`endif
    settle = (inst == 0) ? 1 : ((inst == 1) ? 0 : 2);
    nvec   = (inst == 2) ? 8 : 4;
    total  = nvec * (settle + 1);
    exp_tbl = '0;
    for (int i = 0; i < nvec; i++) exp_tbl[i] = f[i];
    case (inst)
      0: func_a = f[3:0];
      1: func_b = f[3:0];
      default: func_c = f;
    endcase
`ifdef TT_SWEEP_COMPARE_EN
    case (inst)
      0: gold_a = golden[3:0];
      1: gold_b = golden[3:0];
      default: gold_c = golden;
    endcase
    exp_mm = 1'b0;
    exp_fe = '0;
    for (int i = nvec - 1; i >= 0; i--) begin
      if (f[i] != golden[i]) begin
        exp_mm = 1'b1;
        exp_fe = 3'(i);
      end
    end
`endif
    set_start(inst, 1'b1);
    tick;
    set_start(inst, 1'b0);
    for (int k = 1; k <= total; k++) begin
      vec  = (k - 1) / (settle + 1);
      part = '0;
      for (int i = 0; i < nvec; i++) if ((i + 1) * (settle + 1) <= k - 1) part[i] = f[i];
      sample(inst, x, b, d, t);
      checks++;
      if (x !== 3'(vec) || b !== 1'b1 || d !== 1'b0 || t !== part) begin
        failures++;
        $display("FAIL %s run cycle %0d: x=%0d busy=%b done=%b table=%h, want x=%0d busy=1 done=0 table=%h",
                 tag, k, x, b, d, t, vec, part);
      end
      if (k == restart_at) set_start(inst, 1'b1);
      tick;
      set_start(inst, 1'b0);
    end
    sample(inst, x, b, d, t);
    checks++;
    if (x !== 3'd0 || b !== 1'b0 || d !== 1'b1 || t !== exp_tbl) begin
      failures++;
      $display("FAIL %s done cycle: x=%0d busy=%b done=%b table=%h, want x=0 busy=0 done=1 table=%h",
               tag, x, b, d, t, exp_tbl);
    end
`ifdef TT_SWEEP_COMPARE_EN
    sample_cmp(inst, m, fe);
    checks++;
    if (m !== exp_mm || fe !== exp_fe) begin
      failures++;
      $display("FAIL %s compare: mismatch=%b first_err=%0d, want mismatch=%b first_err=%0d",
               tag, m, fe, exp_mm, exp_fe);
    end
`endif
    tick;
    sample(inst, x, b, d, t);
    checks++;
    if (x !== 3'd0 || b !== 1'b0 || d !== 1'b0 || t !== exp_tbl) begin
      failures++;
      $display("FAIL %s idle after done: x=%0d busy=%b done=%b table=%h, want 0 0 0 table=%h",
               tag, x, b, d, t, exp_tbl);
    end
`ifdef TT_SWEEP_COMPARE_EN
    sample_cmp(inst, m, fe);
    checks++;
    if (m !== exp_mm || fe !== exp_fe) begin
      failures++;
      $display("FAIL %s compare hold: mismatch=%b first_err=%0d, want mismatch=%b first_err=%0d",
               tag, m, fe, exp_mm, exp_fe);
    end
`endif
  endtask

  task automatic test_reset;
    logic [2:0] x;
    logic b, d;
    logic [7:0] t;
    reset = 1'b1;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      for (int inst = 0; inst < 3; inst++) begin
        sample(inst, x, b, d, t);
        checks++;
        if (x !== 3'd0 || b !== 1'b0 || d !== 1'b0 || t !== 8'd0) begin
          failures++;
          $display("FAIL reset inst%0d cycle%0d: x=%0d busy=%b done=%b table=%h, want all 0",
                   inst, c, x, b, d, t);
        end
      end
    end
`ifdef TT_SWEEP_COMPARE_EN
    checks++;
    if (mm_a !== 1'b0 || fe_a !== 2'd0) begin
      failures++;
      $display("FAIL reset compare: mismatch=%b first_err=%0d, want 0 0", mm_a, fe_a);
    end
`endif
    reset = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tick;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
      failures++;
      $display("FAIL reset release: busy=%b%b%b, want 000", busy_a, busy_b, busy_c);
    end
  endtask

  // s = ~x & y is true only for vector {x,y} = 01.
  task automatic test_basic;
    sweep(0, 8'b0010, 8'b0010, 0, "basic");
  endtask

  // s = x ^ y, zero settle, run twice.
  task automatic test_zero_settle;
    sweep(1, 8'b0110, 8'b0110, 0, "zero_settle_1");
    sweep(1, 8'b0110, 8'b0000, 0, "zero_settle_2");
  endtask

  task automatic test_start_busy;
    sweep(0, 8'b0010, 8'b0010, 3, "start_busy");
  endtask

  task automatic test_reset_mid;
    int bad;
    func_a = 4'b1111;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 1; k <= 4; k++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || x_a !== 2'd0 || tbl_a !== 4'd0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b x=%0d table=%h done=%b, want 0 0 0 0",
               busy_a, x_a, tbl_a, done_a);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid aftermath: %0d cycles with done/busy set, want 0", bad);
    end
    sweep(0, 8'(4'($urandom)), 8'b0, 0, "reset_mid_fresh");
  endtask

  // start held high on the zero-settle instance: done at E0+4, restart at E0+6, done at E0+10.
  task automatic test_start_held;
    logic [3:0] f;
    logic exp_b, exp_d;
    f = 4'($urandom);
    func_b = f;
    start_b = 1'b1;
    tick;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp_b = (k >= 1 && k <= 3) || (k >= 6 && k <= 9);
      exp_d = (k == 4) || (k == 10);
      checks++;
      if (busy_b !== exp_b || done_b !== exp_d) begin
        failures++;
        $display("FAIL start_held edge %0d: busy=%b done=%b, want busy=%b done=%b",
                 k, busy_b, done_b, exp_b, exp_d);
      end
    end
    checks++;
    if (tbl_b !== f) begin
      failures++;
      $display("FAIL start_held table: got %h, want %h", tbl_b, f);
    end
    start_b = 1'b0;
    tick;
    tick;
    checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      failures++;
      $display("FAIL start_held release: busy=%b done=%b, want 0 0", busy_b, done_b);
    end
  endtask

`ifdef TT_SWEEP_COMPARE_EN
  task automatic test_compare;
    sweep(0, 8'b1000, 8'b0010, 0, "compare_and");
    sweep(0, 8'b0010, 8'b0010, 0, "compare_match");
  endtask
`endif

  task automatic test_random;
    int inst, restart, gap;
    logic [7:0] f, golden;
    for (int n = 0; n < 8; n++) begin
      inst    = int'($urandom_range(0, 2));
      f       = 8'($urandom);
      golden  = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
      restart = int'($urandom_range(0, 6));
      sweep(inst, f, golden, restart, "random");
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_settle();
    test_start_busy();
    test_reset_mid();
    test_start_held();
`ifdef TT_SWEEP_COMPARE_EN
    test_compare();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_sweep.md
Name: tt_sweep

Overview:
- Sequential truth-table sweep engine that sits directly upstream of a combinational logic function (the 2-input s = f(x,y) gate network).
- Drives every input combination in ascending binary order, holds each long enough to settle, samples the function output, and packs the results into a truth-table vector.
- Replaces the hand-written #delay stimulus sequence with a synthesizable, clocked stage.

Parameters:
- N_IN, 2, number of function inputs; legal range 1..4.
- SETTLE, 1, extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- x_out  output  N_IN  current input vector to the function under sweep. For N_IN=2, x_out[1]=x and x_out[0]=y.
- s_in  input  1  function output being captured.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2**N_IN  captured truth table; bit i = s_in observed with x_out==i.

Behaviour:
- Reset: synchronous, active-high. On the edge where reset=1:
  - state=IDLE.
  - x_out, busy, done, table_out, vector index and settle counter all 0.
  - Reset dominates start.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0, x_out=0; table_out holds the last result.
  - start=1 at edge E0 moves to RUN. At the same edge: index=0, settle counter=SETTLE, table_out cleared to 0.
- RUN:
  - busy=1; x_out=index (registered output, no combinational path from start).
  - Each vector is held for SETTLE+1 cycles.
  - Settle counter nonzero: decrement.
  - Settle counter zero: table_out[index] <= s_in at that edge.
    - If index==2**N_IN-1: go to DONE.
    - Otherwise: index+1, settle counter reloads SETTLE, go to the next vector.
- Timing: vector i is sampled at edge E0+(i+1)*(SETTLE+1).
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, x_out=0, table_out final. Then go to IDLE.
  - DONE is entered at edge E0+2**N_IN*(SETTLE+1).
- start while busy or in DONE: ignored, with no effect on index or table.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- Reset mid-sweep: abort, no done pulse, table_out=0.
- Index width: N_IN+1 bits, so the last-vector compare never wraps. No wrap of x_out beyond 2**N_IN-1.
- s_in is assumed combinationally derived from x_out. No synchronizer is required.

Optional Feature:
- Macro: TT_SWEEP_COMPARE_EN.
- Defined: adds three ports.
  - expected (input, 2**N_IN): golden table.
  - mismatch (output, 1).
  - first_err (output, N_IN): lowest index where the captured bit differs from expected.
  - Both outputs update in the DONE cycle and hold until the next start or reset. Both reset to 0.
  - If there is no difference, mismatch=0 and first_err=0.
- Undefined: the three ports and the compare logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles with start=1. Required: busy=0, done=0, x_out=0, table_out=0; no sweep starts while reset=1.
- Basic sweep (N_IN=2, SETTLE=1), s_in = ~x & y, start pulse at E0.
  - x_out sequence 00,00,01,01,10,10,11,11 over the 8 cycles after E0.
  - done=1 exactly 8 edges after E0; table_out=4'b0010.
- Zero settle (N_IN=2, SETTLE=0), s_in = x ^ y: done 4 edges after start; table_out=4'b0110. Repeat the sweep and get an identical result.
- Start while busy: pulse start again at E0+3 during the basic sweep. Required: no restart, same 8-edge done timing, table_out=4'b0010.
- Reset mid-sweep: assert reset at E0+5. Next cycle: busy=0, x_out=0, table_out=0, and no done pulse ever follows. A fresh start then completes normally.
- Compare (TT_SWEEP_COMPARE_EN defined): expected=4'b0010, s_in = x & y.
  - table_out=4'b1000; mismatch=1 and first_err=2'd1 in the DONE cycle.
  - With s_in = ~x & y: mismatch=0, first_err=0.
